// File: rtl/fetch_unit.sv
// RV32I fetch stage: keeps the fetch PC, issues one I-cache request at a time and
// buffers returned instructions with their PCs in a small FIFO for the decoder.
module fetch_unit #(
   parameter int                  PC_SIZE    = 32,
   parameter int                  INSTR_SIZE = 32,
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [PC_SIZE-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_i,
   input  logic [PC_SIZE-1:0]    redirect_pc_i,
   output logic                  ic_req_o,
   output logic [PC_SIZE-1:0]    ic_addr_o,
   input  logic                  ic_gnt_i,
   input  logic                  ic_rvalid_i,
   input  logic [INSTR_SIZE-1:0] ic_rdata_i,
   output logic                  dec_valid_o,
   input  logic                  dec_ready_i,
   output logic [INSTR_SIZE-1:0] dec_instr_o,
   output logic [PC_SIZE-1:0]    dec_pc_o
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

   state_t                  state_reg, state_next;
   logic [PC_SIZE-1:0]      fetch_pc_reg, fetch_pc_next;
   logic [PC_SIZE-1:0]      pend_pc_reg;
   logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]          count_reg, count_next;
   logic [PTR_W:0]          occupancy;
   logic                    fetch_en_reg;
   logic                    space, grant, push, pop;
   logic                    unused_pc_bits;

   logic [INSTR_SIZE-1:0]   instr_mem [FIFO_DEPTH];
   logic [PC_SIZE-1:0]      pc_mem    [FIFO_DEPTH];

   // Occupancy counts the outstanding response as a reserved slot; pops are not credited.
   assign occupancy = count_reg + {{PTR_W{1'b0}}, (state_reg == WAIT)};
   assign space     = occupancy < DEPTH_V;

   always_comb begin
      ic_req_o = 1'b0;
      if (fetch_en_reg && space && !redirect_i)
         ic_req_o = (state_reg == RUN) || ((state_reg == WAIT) && ic_rvalid_i);
   end

   assign ic_addr_o      = fetch_pc_reg;
   assign grant          = ic_req_o & ic_gnt_i;
   assign push           = (state_reg == WAIT) & ic_rvalid_i & ~redirect_i;
   assign pop            = dec_valid_o & dec_ready_i;
   assign unused_pc_bits = ^redirect_pc_i[1:0];

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      count_next    = count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      unique case (state_reg)
         RUN:  if (grant) state_next = WAIT;
         WAIT: begin
            if (redirect_i)
               state_next = ic_rvalid_i ? RUN : DROP;
            else if (ic_rvalid_i && !grant)
               state_next = RUN;
         end
         DROP: if (ic_rvalid_i) state_next = RUN;
         default: state_next = RUN;
      endcase
      if (redirect_i) begin
         fetch_pc_next = {redirect_pc_i[PC_SIZE-1:2], 2'b00};
         count_next    = '0;
      end else if (grant) begin
         fetch_pc_next = fetch_pc_reg + PC_SIZE'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= RUN;
         fetch_pc_reg <= RESET_PC;
         pend_pc_reg  <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         fetch_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         count_reg    <= count_next;
         fetch_en_reg <= 1'b1;
         if (grant)
            pend_pc_reg <= fetch_pc_reg;
         if (redirect_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_reg] <= ic_rdata_i;
         pc_mem[wr_ptr_reg]    <= pend_pc_reg;
      end
   end

   // Head is gated so the decoder sees zeros, not stale storage, while empty.
   assign dec_valid_o = (count_reg != '0);
   assign dec_instr_o = dec_valid_o ? instr_mem[rd_ptr_reg] : '0;
   assign dec_pc_o    = dec_valid_o ? pc_mem[rd_ptr_reg]    : '0;

   rvalid_in_run: assert property (@(posedge clk) disable iff (!rst_n)
      !(ic_rvalid_i && (state_reg == RUN)));

endmodule
